// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: opcodes, FSM states and command-word sizing shared by the shift command sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_LOAD = 2'b01, OP_SHR = 2'b10, OP_SHL = 2'b11} op_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_e;
  function automatic int cmd_w(input int width, input int cnt_w);
    return 2 + width + 1 + cnt_w;
  endfunction
  localparam int CMD_W = cmd_w(8, 4);
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO, wrap-bit pointers
// ports: clock, reset_n (sync, active-low), push/wdata, pop/rdata, full, empty
module cmd_fifo #(
  parameter int W = 15,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clock) if (push && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: queues shift-register ops and drives d/l/sh/shl/si cycle by cycle
// ports: clock, reset_n (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_si/cmd_count in;
//        d, l, sh, shl, si registered strobes; done pulse in last cycle; busy; shadow = predicted register
module shift_cmd_sequencer import shift_seq_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_si,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] d,
  output logic             l,
  output logic             sh,
  output logic             shl,
  output logic             si,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] shadow
);
  localparam int CW = cmd_w(WIDTH, CNT_W);
  state_e state, state_n;
  logic [CNT_W-1:0] remaining;
  logic [CW-1:0] rdata;
  logic full, empty, last, take;
  logic [1:0] f_op;
  logic [WIDTH-1:0] f_data;
  logic f_si;
  logic [CNT_W-1:0] f_count;
  cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push(cmd_valid && cmd_ready),
    .wdata({cmd_op, cmd_data, cmd_si, cmd_count}),
    .pop(take),
    .rdata(rdata),
    .full(full),
    .empty(empty)
  );
  assign {f_op, f_data, f_si, f_count} = rdata;
  assign cmd_ready = !full && reset_n;
  assign busy = state == ST_EXEC || !empty;
  assign done = last;
  always_ff @(posedge clock) state <= !reset_n ? ST_IDLE : state_n;
  // take: pop the next command, either from idle or chained straight after a finishing one
  always_comb begin
    last = state == ST_EXEC && remaining == '0;
    take = !empty && (state == ST_IDLE || last);
    state_n = take ? ST_EXEC : last ? ST_IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      remaining <= '0;
      d <= '0;
      si <= 1'b0;
      l <= 1'b0;
      sh <= 1'b0;
      shl <= 1'b0;
      shadow <= '0;
    end else begin
      remaining <= take ? f_count : remaining != '0 ? remaining - 1'b1 : remaining;
      l <= take ? f_op == OP_LOAD : l && !last;
      sh <= take ? f_op == OP_SHR : sh && !last;
      shl <= take ? f_op == OP_SHL : shl && !last;
      d <= take && f_op == OP_LOAD ? f_data : d;
      si <= take && (f_op == OP_SHR || f_op == OP_SHL) ? f_si : si;
      // mirrors what shift_register does with the strobes it samples on this edge
      shadow <= l ? d : sh ? {si, shadow[WIDTH-1:1]} : shl ? {shadow[WIDTH-2:0], si} : shadow;
    end
  end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb_shift_cmd_sequencer: scoreboard bench with a cycle-level reference model of command timing and shadow
module tb_shift_cmd_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic cmd_si = 1'b0;
  logic [3:0] cmd_count = 4'h0;
  logic [7:0] d, shadow;
  logic l, sh, shl, si, done, busy;
  shift_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
    .clock(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .cmd_si(cmd_si),
    .cmd_count(cmd_count),
    .d(d),
    .l(l),
    .sh(sh),
    .shl(shl),
    .si(si),
    .done(done),
    .busy(busy),
    .shadow(shadow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic       s;
    int         start;
    int         done_c;
    logic [7:0] sh_after;
  } exp_t;
  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cnt = 0;
  int free_c = 0;
  logic [7:0] sh_m = 8'h00;
  logic in_rst = 1'b0;
  logic pend = 1'b0;
  logic [7:0] pend_val = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) in_rst <= !reset_n;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // monitor: compares every cycle against the scoreboard head; pops on done
  always @(negedge clk) begin
    logic act, el, esh, eshl, ed;
    if (in_rst) begin
      chk("rst_outs", 32'({l, sh, shl, si, done, busy}), 32'd0);
      chk("rst_d_shadow", 32'({d, shadow}), 32'd0);
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("shadow_after", 32'(shadow), 32'(pend_val));
        pend = 1'b0;
      end
      act = sb.size() > 0 && cyc >= sb[0].start;
      el = act && sb[0].op == 2'b01;
      esh = act && sb[0].op == 2'b10;
      eshl = act && sb[0].op == 2'b11;
      ed = act && cyc == sb[0].done_c;
      chk("strobes", 32'({l, sh, shl}), 32'({el, esh, eshl}));
      chk("busy", 32'(busy), 32'(sb.size() > 0));
      if (el) chk("d", 32'(d), 32'(sb[0].data));
      if (esh || eshl) chk("si", 32'(si), 32'(sb[0].s));
      chk("done", 32'(done), 32'(ed));
      if (done) done_cnt++;
      if ((ed || done) && sb.size() > 0) begin
        pend = 1'b1;
        pend_val = sb[0].sh_after;
        void'(sb.pop_front());
      end
    end
  end
  task automatic push(input logic [1:0] op, input logic [7:0] data, input logic s, input logic [3:0] cnt);
    int n = 0;
    int k;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    cmd_si = s;
    cmd_count = cnt;
    while (!cmd_ready && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (!cmd_ready) begin
      nchk++;
      nerr++;
      $display("FAIL push_timeout: ready stayed %0b expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    k = cyc + 1;
    e.start = (k + 1 > free_c) ? k + 1 : free_c;
    e.done_c = e.start + int'(cnt);
    free_c = e.done_c + 1;
    for (int i = 0; i <= int'(cnt); i++)
      sh_m = op == 2'b01 ? data : op == 2'b10 ? {s, sh_m[7:1]} : op == 2'b11 ? {sh_m[6:0], s} : sh_m;
    e.op = op;
    e.data = data;
    e.s = s;
    e.sh_after = sh_m;
    @(posedge clk); #2;
    sb.push_back(e);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() > 0) begin
      nchk++;
      nerr++;
      $display("FAIL idle_timeout: %0d commands pending expected 0", sb.size());
    end
    repeat (2) begin @(posedge clk); #2; end
  endtask
  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    @(posedge clk); #2;
    sb.delete();
    sh_m = 8'h00;
    free_c = 0;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    repeat (cycles - 1) begin @(posedge clk); #2; end
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_release", 32'(cmd_ready), 32'd1);
  endtask
  initial begin
    int d0;
    #2;
    do_reset(3);
    chk("reset_shadow", 32'(shadow), 32'd0);
    d0 = done_cnt;
    push(2'b01, 8'h49, 1'b0, 4'd0);
    wait_idle();
    chk("tp1_shadow", 32'(shadow), 32'h49);
    chk("tp1_busy", 32'(busy), 32'd0);
    chk("tp1_dones", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    push(2'b01, 8'h49, 1'b0, 4'd0);
    push(2'b10, 8'h00, 1'b1, 4'd0);
    push(2'b11, 8'h00, 1'b0, 4'd2);
    wait_idle();
    chk("tp2_shadow", 32'(shadow), 32'h20);
    chk("tp2_dones", 32'(done_cnt - d0), 32'd3);
    push(2'b01, 8'hFF, 1'b0, 4'd0);
    push(2'b10, 8'h00, 1'b0, 4'd1);
    wait_idle();
    chk("tp3_shadow", 32'(shadow), 32'h3F);
    push(2'b00, 8'h00, 1'b0, 4'd15);
    push(2'b01, 8'h11, 1'b0, 4'd0);
    push(2'b10, 8'h00, 1'b1, 4'd1);
    push(2'b11, 8'h00, 1'b1, 4'd0);
    push(2'b01, 8'hC3, 1'b0, 4'd2);
    chk("tp4_full_ready", 32'(cmd_ready), 32'd0);
    push(2'b10, 8'h00, 1'b0, 4'd0);
    wait_idle();
    chk("tp4_shadow", 32'(shadow), 32'h61);
    d0 = done_cnt;
    push(2'b00, 8'hAA, 1'b1, 4'd3);
    wait_idle();
    chk("tp5_shadow", 32'(shadow), 32'h61);
    chk("tp5_dones", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    push(2'b11, 8'h00, 1'b1, 4'd7);
    push(2'b01, 8'h5A, 1'b0, 4'd0);
    push(2'b10, 8'h00, 1'b1, 4'd0);
    @(posedge clk); #2;
    do_reset(2);
    repeat (30) begin @(posedge clk); #2; end
    chk("tp6_dones", 32'(done_cnt - d0), 32'd0);
    chk("tp6_shadow", 32'(shadow), 32'd0);
    for (int i = 0; i < 60; i++) begin
      logic [3:0] c;
      c = $urandom_range(0, 4) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      push(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)), c);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
    end
    wait_idle();
    chk("rand_shadow", 32'(shadow), 32'(sh_m));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command sequencer directly upstream of `shift_register`. It accepts queued shift-register operations (LOAD, SHIFT RIGHT, SHIFT LEFT, HOLD), each with a repeat count, over a valid/ready handshake. It drives the register's `d`, `l`, `sh`, `shl` and `si` inputs cycle by cycle, so the control pattern that is currently hand-sequenced in benches becomes a hardware stage. It also keeps a shadow copy of the expected register contents for checking and observability.

## Interface
- `WIDTH`, 8: data width; equals `shift_register` width.
- `DEPTH`, 4: command queue depth; power of two, ≥2.
- `CNT_W`, 4: repeat-count width.

Ports:
- `clock`  in  1: single clock; all state is updated on the rising edge.
- `reset_n`  in  1: reset, synchronous and active-low.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: queue can accept a command; equals `!full && reset_n`.
- `cmd_op`  in  2: 00 HOLD, 01 LOAD, 10 SHR, 11 SHL.
- `cmd_data`  in  WIDTH: load value; ignored for the other opcodes.
- `cmd_si`  in  1: serial-in bit for shifts.
- `cmd_count`  in  CNT_W: the operation is applied `cmd_count+1` cycles.
- `d`  out  WIDTH: to `shift_register.d`.
- `l`, `sh`, `shl`, `si`  out  1 each: to `shift_register`.
- `done`  out  1: one-cycle pulse in the last active cycle of each command.
- `busy`  out  1: a command is executing or the queue is non-empty.
- `shadow`  out  WIDTH: predicted `shift_register.out`.

## Operation
- A handshake completes on an edge where `cmd_valid && cmd_ready`. The fields `{op,data,si,count}` are pushed into a FIFO. There is no combinational bypass.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop, load `op/data/si` and `remaining=count`, then go to EXEC.
  - EXEC: drive the controls for the current op each cycle.
    - If `remaining!=0`: decrement `remaining`.
    - If `remaining==0`: assert `done`. If the FIFO is non-empty, pop and stay in EXEC with the new command, so there is no gap cycle. Otherwise go to IDLE.
- Control encoding is registered and one-hot or zero:
  - LOAD: `l=1`, `d=data`.
  - SHR: `sh=1`, `si=cmd_si`.
  - SHL: `shl=1`, `si=cmd_si`.
  - HOLD: all strobes 0.
  - IDLE: all strobes 0.
  - `d` and `si` keep their last values when not in use.
- Shadow update, on the same edge at which `shift_register` samples the strobes:
  - LOAD: `shadow <= d`.
  - SHR: `shadow <= {si, shadow[WIDTH-1:1]}`.
  - SHL: `shadow <= {shadow[WIDTH-2:0], si}`.
  - HOLD/IDLE: unchanged.
- Full FIFO: `cmd_ready=0`, so no push occurs. A push and a pop on the same edge leave the occupancy unchanged. A pop on an empty FIFO never occurs.
- Commands execute in strict FIFO order and none are dropped or reordered.

## Timing
- Reset (`reset_n=0` at an edge) sets:
  - state IDLE, FIFO empty;
  - `d=0`, `l=sh=shl=si=0`, `done=0`, `shadow=0`;
  - `busy=0` and `cmd_ready=0` while reset is held. `cmd_ready` returns to 1 in the first cycle after release.
- Latency: with an idle sequencer, a command accepted at edge k is popped at edge k+1. Its strobes are high for cycles k+1 … k+1+count, and `shift_register` samples them at edges k+2 … k+2+count. `shadow` matches the register after each of those edges.
- `done` is high during cycle k+1+count only.
- Back-to-back commands: the next command's strobes follow in the very next cycle after the previous `done` cycle.
- Reset mid-operation: queued and executing commands are discarded, strobes drop at that edge, and no `done` is issued.
- The count wraps only through the `+1` rule: the maximum of `2^CNT_W` cycles occurs at `count=2^CNT_W-1`.

## Structure
- Package `shift_seq_pkg`: opcode constants (`OP_HOLD`, `OP_LOAD`, `OP_SHR`, `OP_SHL`), FSM state encoding (`ST_IDLE`, `ST_EXEC`), and the packed command-word width `2+WIDTH+1+CNT_W`.
- Sub-module `cmd_fifo`: synchronous FIFO with parameterised width/depth, `full`/`empty`, pointer-based with an extra wrap bit, and the same `clock`/`reset_n`.
- Top level: FSM, remaining counter, registered control outputs, shadow register.

## Test plan
- After reset, LOAD 0x49 with count 0: `l` high for exactly 1 cycle with `d=0x49`, then `shadow=0x49`, one `done`, `busy` returns to 0.
- LOAD 0x49, then SHR si=1 count 0, then SHL si=0 count 2: `shadow` goes 0x49 → 0xA4 → 0x48 → 0x90 → 0x20, and exactly 3 `done` pulses are seen.
- LOAD 0xFF then SHR si=0 count 1, pushed back-to-back: `l` in cycle n and `sh` in cycles n+1 and n+2 with no gap; `shadow` goes 0xFF → 0x7F → 0x3F.
- HOLD count 15 executing, then push 5 further commands: 4 are accepted, `cmd_ready` drops, the 5th is held until the first pop, and all 5 execute in order.
- HOLD count 3: 4 cycles with `l=sh=shl=0`, `shadow` unchanged, one `done`.
- SHL count 7 with 2 commands queued; `reset_n` is pulled low in the 3rd active cycle: strobes, `busy` and `shadow` are 0 at the next cycle, no `done` is issued, and the queued commands never execute.
